// File: rtl/frame_read_sched_pkg.sv
// Shared types and constants for the frame read scheduler.
package frame_read_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic SEL_H = 1'b0;
  localparam logic SEL_V = 1'b1;

endpackage

// File: rtl/frame_read_sched_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, tie goes to the FIFO not served last.
module rr_arb2
  import frame_read_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

  logic       r_last;
  logic [1:0] w_grant;

  // Grant decode; bit 0 = horizontal, bit 1 = vertical.
  always_comb begin
    w_grant = 2'b00;
    case (i_req)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = (r_last == SEL_V) ? 2'b01 : 2'b10;
      default: w_grant = 2'b00;
    endcase
  end

  assign o_grant = w_grant;

  // Remember who was served so the next tie flips.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last <= SEL_V;
    end else if (i_en && (w_grant != 2'b00)) begin
      r_last <= w_grant[1];
    end
  end

endmodule

// File: rtl/frame_read_sched.sv
// Frame read scheduler: arbitrates two FIFOs and reads WINDOW samples per frame,
// then drains the read pipeline and holds the feature blocks in reset for GAP cycles.
module frame_read_sched
  import frame_read_sched_pkg::*;
#(
  parameter int WINDOW = 64,
  parameter int GAP    = 4,
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       h_almost_full,
  input  logic       h_empty,
  input  logic       v_almost_full,
  input  logic       v_empty,
  output logic       h_rd_en,
  output logic       v_rd_en,
  output logic       sel,
  output logic       frame_start,
  output logic       sample_valid,
  output logic       frame_last,
  output logic       feat_reset,
  output logic       busy,
  output logic [7:0] frame_count,
  output logic       underrun
);

  localparam logic [7:0] WIN     = 8'(WINDOW);
  localparam logic [3:0] DRAIN_T = 4'(RD_LAT - 1);
  localparam logic [3:0] GAP_T   = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_cnt;
  logic [3:0]        r_tmr;
  logic [RD_LAT-1:0] r_sv_dly;
  logic [RD_LAT-1:0] r_fl_dly;
  logic              r_rd_last;
  logic              r_h_rd_en;
  logic              r_v_rd_en;
  logic              r_sel;
  logic              r_frame_start;
  logic              r_feat_reset;
  logic              r_busy;
  logic [7:0]        r_frame_count;
  logic              r_underrun;
  logic [1:0]        w_grant;
  logic              w_granted;
  logic              w_sel_empty;
  logic              w_want_rd;
  logic              w_issue;
  logic              w_stall;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_en    (r_state == ST_IDLE),
    .i_req   ({v_almost_full, h_almost_full}),
    .o_grant (w_grant)
  );

  assign w_granted   = (r_state == ST_IDLE) && (w_grant != 2'b00);
  assign w_sel_empty = (r_sel == SEL_V) ? v_empty : h_empty;
  // A read is wanted for the cycle after GRANT and every READ cycle short of WINDOW.
  assign w_want_rd   = (r_state == ST_GRANT) || ((r_state == ST_READ) && (r_cnt < WIN));
  assign w_issue     = w_want_rd && !w_sel_empty;
  assign w_stall     = w_want_rd && w_sel_empty;

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_granted) w_state_nxt = ST_GRANT;
        else           w_state_nxt = ST_IDLE;
      end
      ST_GRANT: w_state_nxt = ST_READ;
      ST_READ: begin
        if (r_cnt == WIN) w_state_nxt = ST_DRAIN;
        else              w_state_nxt = ST_READ;
      end
      ST_DRAIN: begin
        if (r_tmr != 4'd0) w_state_nxt = ST_DRAIN;
        else if (GAP != 0) w_state_nxt = ST_GAP;
        else               w_state_nxt = ST_IDLE;
      end
      ST_GAP: begin
        if (r_tmr != 4'd0) w_state_nxt = ST_GAP;
        else               w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, counters, delay lines and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 8'd0;
      r_tmr         <= 4'd0;
      r_sv_dly      <= '0;
      r_fl_dly      <= '0;
      r_rd_last     <= 1'b0;
      r_h_rd_en     <= 1'b0;
      r_v_rd_en     <= 1'b0;
      r_sel         <= SEL_H;
      r_frame_start <= 1'b0;
      r_feat_reset  <= 1'b1;
      r_busy        <= 1'b0;
      r_frame_count <= 8'd0;
      r_underrun    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_frame_start <= (w_state_nxt == ST_GRANT);
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_feat_reset  <= (w_state_nxt == ST_IDLE);
      r_h_rd_en     <= w_issue && (r_sel == SEL_H);
      r_v_rd_en     <= w_issue && (r_sel == SEL_V);
      r_rd_last     <= w_issue && (r_cnt == (WIN - 8'd1));

      if (w_granted) begin
        r_sel <= w_grant[1];
        r_cnt <= 8'd0;
      end else if (w_issue) begin
        r_cnt <= r_cnt + 8'd1;
      end

      if (w_stall) begin
        r_underrun <= 1'b1;
      end

      case (r_state)
        ST_READ:  r_tmr <= DRAIN_T;
        ST_DRAIN: r_tmr <= (r_tmr == 4'd0) ? GAP_T : (r_tmr - 4'd1);
        ST_GAP:   r_tmr <= (r_tmr == 4'd0) ? 4'd0 : (r_tmr - 4'd1);
        default:  r_tmr <= 4'd0;
      endcase

      // Sample qualifiers follow the read enables by the FIFO read latency.
      r_sv_dly[0] <= r_h_rd_en | r_v_rd_en;
      r_fl_dly[0] <= r_rd_last;
      for (int i = 1; i < RD_LAT; i++) begin
        r_sv_dly[i] <= r_sv_dly[i-1];
        r_fl_dly[i] <= r_fl_dly[i-1];
      end

      if (r_fl_dly[RD_LAT-1]) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign h_rd_en      = r_h_rd_en;
  assign v_rd_en      = r_v_rd_en;
  assign sel          = r_sel;
  assign frame_start  = r_frame_start;
  assign sample_valid = r_sv_dly[RD_LAT-1];
  assign frame_last   = r_fl_dly[RD_LAT-1];
  assign feat_reset   = r_feat_reset;
  assign busy         = r_busy;
  assign frame_count  = r_frame_count;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_frame_read_sched.sv
// Directed bench for frame_read_sched with default parameters (WINDOW=64, GAP=4, RD_LAT=1).
module tb_frame_read_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       h_almost_full = 1'b0;
  logic       h_empty = 1'b0;
  logic       v_almost_full = 1'b0;
  logic       v_empty = 1'b0;
  logic       h_rd_en, v_rd_en, sel, frame_start, sample_valid, frame_last;
  logic       feat_reset, busy, underrun;
  logic [7:0] frame_count;

  int vectors = 0;
  int miscompares = 0;
  int m_overlap = 0;

  // {h_rd_en,v_rd_en,sel,frame_start,sample_valid,frame_last,feat_reset,busy,underrun,frame_count}
  localparam logic [16:0] RST_SNAP = {8'b0000_0010, 1'b0, 8'd0};

  logic        a_hr[0:199], a_vr[0:199], a_sl[0:199], a_fs[0:199], a_sv[0:199];
  logic        a_fl[0:199], a_fr[0:199], a_bz[0:199], a_ur[0:199];
  logic [7:0]  a_fc[0:199];
  logic [16:0] a_snap[0:199];

  frame_read_sched dut (
    .clk           (clk),
    .reset         (reset),
    .h_almost_full (h_almost_full),
    .h_empty       (h_empty),
    .v_almost_full (v_almost_full),
    .v_empty       (v_empty),
    .h_rd_en       (h_rd_en),
    .v_rd_en       (v_rd_en),
    .sel           (sel),
    .frame_start   (frame_start),
    .sample_valid  (sample_valid),
    .frame_last    (frame_last),
    .feat_reset    (feat_reset),
    .busy          (busy),
    .frame_count   (frame_count),
    .underrun      (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] snap();
    return {h_rd_en, v_rd_en, sel, frame_start, sample_valid, frame_last,
            feat_reset, busy, underrun, frame_count};
  endfunction

  // Records n cycles (sampled on negedge, cycle 1 = first cycle after the request edge)
  // and drives requests / h_empty window / reset-at-read-k for the following edge.
  task automatic watch(input int n, input int h_hold, input int v_hold,
                       input int emp_from, input int emp_len, input int rst_read);
    int reads;
    bit did_rst;
    reads = 0;
    did_rst = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      a_hr[c] = h_rd_en; a_vr[c] = v_rd_en; a_sl[c] = sel; a_fs[c] = frame_start;
      a_sv[c] = sample_valid; a_fl[c] = frame_last; a_fr[c] = feat_reset;
      a_bz[c] = busy; a_ur[c] = underrun; a_fc[c] = frame_count; a_snap[c] = snap();
      if (h_rd_en && v_rd_en) m_overlap++;
      if (h_rd_en || v_rd_en) reads++;
      h_almost_full = (c < h_hold);
      v_almost_full = (c < v_hold);
      h_empty = (emp_len > 0) && (c >= emp_from) && (c < emp_from + emp_len);
      if (rst_read > 0 && reads == rst_read && !did_rst) begin
        reset = 1'b0;
        did_rst = 1'b1;
      end else begin
        reset = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (snap() !== RST_SNAP) begin miscompares++; $display("FAIL reset_hold: got %h expected %h", snap(), RST_SNAP); end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (snap() !== RST_SNAP) begin miscompares++; $display("FAIL reset_idle: got %h expected %h", snap(), RST_SNAP); end
  endtask

  task automatic test_tie();
    int hcnt, vcnt, hfirst, vfirst, vlast, fscnt;
    hcnt = 0; vcnt = 0; hfirst = 0; vfirst = 0; vlast = 0; fscnt = 0;
    h_almost_full = 1'b1;
    v_almost_full = 1'b1;
    watch(145, 75, 75, 0, 0, 0);
    for (int c = 1; c <= 145; c++) begin
      if (a_hr[c]) begin hcnt++; if (hfirst == 0) hfirst = c; end
      if (a_vr[c]) begin vcnt++; if (vfirst == 0) vfirst = c; vlast = c; end
      if (a_fs[c]) fscnt++;
    end
    vectors++; if (a_sl[1] !== 1'b0) begin miscompares++; $display("FAIL tie_first_sel: got %0d expected 0", a_sl[1]); end
    vectors++; if (hfirst != 2) begin miscompares++; $display("FAIL tie_h_first_rd: got %0d expected 2", hfirst); end
    vectors++; if (hcnt != 64) begin miscompares++; $display("FAIL tie_h_reads: got %0d expected 64", hcnt); end
    vectors++; if (a_sl[72] !== 1'b1 || a_fs[72] !== 1'b1) begin miscompares++; $display("FAIL tie_second_grant: got sel=%0d fs=%0d expected 1 1", a_sl[72], a_fs[72]); end
    vectors++; if (vcnt != 64 || vfirst != 73 || vlast != 136) begin miscompares++; $display("FAIL tie_v_reads: got %0d %0d..%0d expected 64 73..136", vcnt, vfirst, vlast); end
    vectors++; if (fscnt != 2) begin miscompares++; $display("FAIL tie_frame_starts: got %0d expected 2", fscnt); end
    vectors++; if (a_fc[145] !== 8'd2) begin miscompares++; $display("FAIL tie_frame_count: got %0d expected 2", a_fc[145]); end
    vectors++; if (m_overlap != 0) begin miscompares++; $display("FAIL tie_rd_overlap: got %0d expected 0", m_overlap); end
    vectors++; if (a_bz[145] !== 1'b0) begin miscompares++; $display("FAIL tie_idle_after: got busy=%0d expected 0", a_bz[145]); end
  endtask

  task automatic test_single_h();
    int hcnt, vcnt, hfirst, hlast, svcnt, flcnt, frrise;
    hcnt = 0; vcnt = 0; hfirst = 0; hlast = 0; svcnt = 0; flcnt = 0; frrise = 0;
    h_almost_full = 1'b1;
    watch(80, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 80; c++) begin
      if (a_hr[c]) begin hcnt++; if (hfirst == 0) hfirst = c; hlast = c; end
      if (a_vr[c]) vcnt++;
      if (a_sv[c]) svcnt++;
      if (a_fl[c]) flcnt++;
      if (c > 1 && a_fr[c] && frrise == 0) frrise = c;
    end
    vectors++; if (a_fs[1] !== 1'b1 || a_fr[1] !== 1'b0 || a_sl[1] !== 1'b0) begin miscompares++; $display("FAIL single_grant: got fs=%0d fr=%0d sel=%0d expected 1 0 0", a_fs[1], a_fr[1], a_sl[1]); end
    vectors++; if (hfirst != 2 || hlast != 65 || hcnt != 64) begin miscompares++; $display("FAIL single_h_reads: got %0d..%0d n=%0d expected 2..65 n=64", hfirst, hlast, hcnt); end
    vectors++; if (vcnt != 0) begin miscompares++; $display("FAIL single_v_reads: got %0d expected 0", vcnt); end
    vectors++; if (svcnt != 64 || a_sv[3] !== 1'b1 || a_sv[66] !== 1'b1) begin miscompares++; $display("FAIL single_sample_valid: got n=%0d expected 64 spanning 3..66", svcnt); end
    vectors++; if (flcnt != 1 || a_fl[66] !== 1'b1) begin miscompares++; $display("FAIL single_frame_last: got n=%0d at66=%0d expected 1 1", flcnt, a_fl[66]); end
    vectors++; if (a_fc[66] !== 8'd2 || a_fc[67] !== 8'd3) begin miscompares++; $display("FAIL single_frame_count: got %0d,%0d expected 2,3", a_fc[66], a_fc[67]); end
    vectors++; if (frrise != 71) begin miscompares++; $display("FAIL single_feat_reset_rise: got %0d expected 71", frrise); end
    vectors++; if (a_bz[70] !== 1'b1 || a_bz[71] !== 1'b0) begin miscompares++; $display("FAIL single_busy: got %0d,%0d expected 1,0", a_bz[70], a_bz[71]); end
    vectors++; if (a_ur[80] !== 1'b0) begin miscompares++; $display("FAIL single_underrun: got %0d expected 0", a_ur[80]); end
  endtask

  task automatic test_empty_stall();
    int hcnt, hlast, hole, frrise;
    hcnt = 0; hlast = 0; hole = 0; frrise = 0;
    h_almost_full = 1'b1;
    watch(90, 0, 0, 20, 5, 0);
    for (int c = 1; c <= 90; c++) begin
      if (a_hr[c]) begin hcnt++; hlast = c; if (c >= 21 && c <= 25) hole++; end
      if (c > 1 && a_fr[c] && frrise == 0) frrise = c;
    end
    vectors++; if (hcnt != 64) begin miscompares++; $display("FAIL stall_total_reads: got %0d expected 64", hcnt); end
    vectors++; if (hole != 0 || hlast != 70) begin miscompares++; $display("FAIL stall_window: got hole=%0d last=%0d expected 0 70", hole, hlast); end
    vectors++; if (frrise != 76) begin miscompares++; $display("FAIL stall_feat_reset_rise: got %0d expected 76", frrise); end
    vectors++; if (a_ur[20] !== 1'b0 || a_ur[90] !== 1'b1) begin miscompares++; $display("FAIL stall_underrun: got %0d,%0d expected 0,1", a_ur[20], a_ur[90]); end
    vectors++; if (a_fc[90] !== 8'd4) begin miscompares++; $display("FAIL stall_frame_count: got %0d expected 4", a_fc[90]); end
  endtask

  task automatic test_reset_mid_frame();
    int reads;
    reads = 0;
    v_almost_full = 1'b1;
    watch(60, 0, 0, 0, 0, 30);
    for (int c = 1; c <= 60; c++) begin
      if (a_hr[c] || a_vr[c]) reads++;
    end
    vectors++; if (a_vr[31] !== 1'b1 || a_sl[31] !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre: got v_rd=%0d sel=%0d expected 1 1", a_vr[31], a_sl[31]); end
    vectors++; if (a_snap[32] !== RST_SNAP) begin miscompares++; $display("FAIL rstmid_values: got %h expected %h", a_snap[32], RST_SNAP); end
    vectors++; if (reads != 30) begin miscompares++; $display("FAIL rstmid_reads: got %0d expected 30", reads); end
    vectors++; if (a_bz[60] !== 1'b0 || a_fr[60] !== 1'b1) begin miscompares++; $display("FAIL rstmid_idle: got busy=%0d fr=%0d expected 0 1", a_bz[60], a_fr[60]); end
  endtask

  task automatic test_wrap();
    int fs_total;
    fs_total = 0;
    for (int f = 1; f <= 256; f++) begin
      h_almost_full = 1'b1;
      watch(71, 0, 0, 0, 0, 0);
      for (int c = 1; c <= 71; c++) begin
        if (a_fs[c]) fs_total++;
      end
      if (f == 255) begin
        vectors++; if (frame_count !== 8'd255) begin miscompares++; $display("FAIL wrap_255: got %0d expected 255", frame_count); end
      end
    end
    vectors++; if (frame_count !== 8'd0) begin miscompares++; $display("FAIL wrap_zero: got %0d expected 0", frame_count); end
    vectors++; if (fs_total != 256) begin miscompares++; $display("FAIL wrap_frames: got %0d expected 256", fs_total); end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single_h();
    test_empty_stall();
    test_reset_mid_frame();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
